// File: rtl/sha256_round_ctrl_if.sv
// Control bundle between the SHA-256 round controller, the message-schedule
// front end, the round datapath and the digest consumer.
interface sha256_round_ctrl_if;
  logic       start_i;
  logic       blk_valid_i;
  logic       blk_last_i;
  logic       blk_ready_o;
  logic       iv_load_o;
  logic       wv_load_o;
  logic       rnd_en_o;
  logic [5:0] k1_idx_o;
  logic [5:0] k2_idx_o;
  logic       h_acc_o;
  logic       busy_o;
  logic       digest_valid_o;
  logic       digest_ready_i;

  modport slave (
    input  start_i, blk_valid_i, blk_last_i, digest_ready_i,
    output blk_ready_o, iv_load_o, wv_load_o, rnd_en_o, k1_idx_o, k2_idx_o,
           h_acc_o, busy_o, digest_valid_o
  );

  modport master (
    output start_i, blk_valid_i, blk_last_i, digest_ready_i,
    input  blk_ready_o, iv_load_o, wv_load_o, rnd_en_o, k1_idx_o, k2_idx_o,
           h_acc_o, busy_o, digest_valid_o
  );
endinterface

// File: rtl/sha256_round_ctrl.sv
// Sequencer for a 2-round-unrolled SHA-256 compression datapath: loads H and
// a..h, steps 32 double-rounds of STEP_CYC cycles each, then folds into H.
module sha256_round_ctrl #(
  parameter int STEP_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  sha256_round_ctrl_if.slave bus
);
  localparam int SW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam logic [SW-1:0] S_LAST = SW'(STEP_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BLK,
    ROUND,
    ACC,
    DONE
  } state_t;

  state_t        r_state;
  state_t        w_stateNext;
  logic [4:0]    r_j;
  logic [4:0]    w_jNext;
  logic [SW-1:0] r_s;
  logic [SW-1:0] w_sNext;
  logic          r_last;
  logic          w_lastNext;
  logic          r_ivLoad;
  logic          w_ivLoadNext;
  logic          r_wvLoad;
  logic          w_wvLoadNext;
  logic          w_rndFire;

  // The wv_load cycle is spent in ROUND but must not count as part of a step,
  // so the first double-round completes STEP_CYC cycles after the load.
  assign w_rndFire = (r_state == ROUND) && !r_wvLoad && (r_s == S_LAST);

  always_comb begin
    w_stateNext  = r_state;
    w_jNext      = r_j;
    w_sNext      = r_s;
    w_lastNext   = r_last;
    w_ivLoadNext = 1'b0;
    w_wvLoadNext = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start_i) begin
          w_stateNext  = WAIT_BLK;
          w_ivLoadNext = 1'b1;
        end
      end
      WAIT_BLK: begin
        if (bus.blk_valid_i) begin
          w_stateNext  = ROUND;
          w_wvLoadNext = 1'b1;
          w_lastNext   = bus.blk_last_i;
          w_jNext      = '0;
          w_sNext      = '0;
        end
      end
      ROUND: begin
        if (w_rndFire) begin
          w_sNext = '0;
          if (r_j == 5'd31) begin
            w_stateNext = ACC;
          end else begin
            w_jNext = r_j + 5'd1;
          end
        end else if (!r_wvLoad) begin
          w_sNext = r_s + SW'(1);
        end
      end
      ACC: begin
        w_stateNext = r_last ? DONE : WAIT_BLK;
      end
      DONE: begin
        if (bus.digest_ready_i) begin
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_j      <= '0;
      r_s      <= '0;
      r_last   <= 1'b0;
      r_ivLoad <= 1'b0;
      r_wvLoad <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_j      <= w_jNext;
      r_s      <= w_sNext;
      r_last   <= w_lastNext;
      r_ivLoad <= w_ivLoadNext;
      r_wvLoad <= w_wvLoadNext;
    end
  end

  assign bus.blk_ready_o    = (r_state == WAIT_BLK);
  assign bus.iv_load_o      = r_ivLoad;
  assign bus.wv_load_o      = r_wvLoad;
  assign bus.rnd_en_o       = w_rndFire;
  assign bus.k1_idx_o       = {r_j, 1'b0};
  assign bus.k2_idx_o       = {r_j, 1'b1};
  assign bus.h_acc_o        = (r_state == ACC);
  assign bus.busy_o         = (r_state != IDLE);
  assign bus.digest_valid_o = (r_state == DONE);
endmodule
